fsub_seq: RTL and testbench
===========================

FSUB_SEQ -- requirements
Module: fsub_seq

Interface
REQ-001 The block SHALL have these ports, one clock domain:
- clk        input   1   rising-edge clock
- rst        input   1   asynchronous, active-high reset
- in_valid   input   1   operand pair valid
- in_ready   output  1   block can accept operands
- a          input   16  minuend, IEEE-754 binary16 (1 sign, 5 exp bias 15, 10 frac)
- b          input   16  subtrahend, binary16
- out_valid  output  1   result valid
- out_ready  input   1   consumer accepts result
- result     output  16  binary16 value of a - b
- busy       output  1   high whenever state != IDLE

Function
REQ-002 The block SHALL accept operands on a rising edge where in_valid && in_ready; in_ready SHALL equal (state == IDLE).
REQ-003 The FSM states SHALL be IDLE, ALIGN, ARITH, NORM, PACK, DONE.
REQ-004 Transitions SHALL be:
- IDLE->ALIGN on accept
- ALIGN->ARITH->NORM unconditionally
- NORM->NORM while normalising
- NORM->PACK when normalised
- PACK->DONE
- DONE->IDLE on out_ready
REQ-005 Unpacking SHALL treat exp==0 inputs as signed zero (denormals flushed) and SHALL invert the sign of b before processing.
REQ-006 ALIGN SHALL right-shift the smaller-magnitude 11-bit significand by the exponent difference into a 14-bit working field (guard, round, sticky); the sticky bit is the OR of all shifted-out bits.
REQ-007 ARITH SHALL add the magnitudes on equal effective signs and subtract smaller from larger otherwise; the result sign is the sign of the larger-magnitude operand.
REQ-008 In NORM, each cycle SHALL do exactly one of:
- on carry-out: shift right 1, sticky-preserving, exp+1
- else if hidden bit clear, significand nonzero and exp>1: shift left 1, exp-1
- else exit to PACK
REQ-009 out_valid SHALL rise exactly 4+k cycles after the accept edge, where k (0..11) is the number of NORM shift cycles.
REQ-010 In DONE, result and out_valid SHALL be held stable until out_ready is high; out_valid SHALL drop on the edge where out_ready is sampled high.
REQ-011 Special cases SHALL resolve in PACK:
- any NaN input -> 0x7E00
- inf - inf of the same sign -> 0x7E00
- one infinity -> that infinity with the effective sign
- exact cancellation -> 0x0000
- exponent >= 31 after rounding -> signed infinity
- exponent < 1 -> signed zero
REQ-012 in_valid asserted while busy SHALL be ignored; no operands are queued.

Reset
REQ-013 While rst is high, asynchronously:
- state = IDLE
- out_valid = 0
- result = 0x0000
- all datapath registers = 0
REQ-014 Reset asserted in any state, including mid-NORM, SHALL abandon the operation; after release in_ready SHALL be 1 and no stale result SHALL appear.

Configuration
REQ-015 With macro FSUB_SEQ_RNE_EN defined, PACK SHALL round to nearest, ties to even, using guard/round/sticky; a rounding carry SHALL renormalise within PACK without extra cycles.
REQ-016 Without FSUB_SEQ_RNE_EN, PACK SHALL truncate (round toward zero); latency SHALL be identical in both builds.

Structure
REQ-017 Package fsub_pkg SHALL hold:
- field widths (EXP_W=5, FRAC_W=10, WORK_W=14)
- BIAS=15
- canonical NaN 0x7E00
- state enumeration
REQ-018 Sub-module fsub_align_shift SHALL implement the one-cycle sticky right shifter used in ALIGN; all other logic stays in fsub_seq.

Verification
REQ-019 The bench SHALL cover these scenarios:
- 0x4200 - 0x3C00 (3-1) -> result 0x4000; out_valid 4 cycles after accept (k=0)
- 0x3C00 - 0xBC00 (1-(-1)) -> 0x4000; out_valid 5 cycles after accept (carry, k=1)
- 0x3C00 - 0x3C00 -> 0x0000; 0x7C00 - 0x7C00 -> 0x7E00
- 0x6800 - 0x3800 (2048-0.5) -> 0x6800 with FSUB_SEQ_RNE_EN, 0x67FF without
- Hold out_ready low 3 cycles in DONE -> result and out_valid stable, in_ready 0, in_valid pulses ignored; release -> IDLE next cycle
- Assert rst for 1 cycle during NORM of 0x3C01 - 0x3C00 -> out_valid 0, in_ready 1; next operation returns the correct result

Source files
------------

// File: rtl/fsub_pkg.sv
// fsub_pkg: shared widths, constants, FSM encoding and operand unpacking
// for the sequential binary16 subtractor.
package fsub_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int SIG_W  = FRAC_W + 1;       // significand with hidden bit
    localparam int WORK_W = 14;               // significand + guard/round/sticky
    localparam int EXPX_W = 7;                // widened exponent, absorbs carries
    localparam int BIAS   = 15;

    localparam logic [15:0] NAN_CANON = 16'h7E00;
    localparam logic [14:0] INF_MAG   = 15'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ARITH,
        NORM,
        PACK,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_nan;
        logic             is_inf;
    } operand_t;

    // Split a binary16 word; exp==0 becomes a signed zero (no denormals).
    function automatic operand_t unpack_op(input logic [15:0] x, input logic flip_sign);
        operand_t op;
        op.sign   = x[15] ^ flip_sign;
        op.exp    = x[14:10];
        op.sig    = (x[14:10] == '0) ? '0 : {1'b1, x[9:0]};
        op.is_nan = (x[14:10] == '1) && (x[9:0] != '0);
        op.is_inf = (x[14:10] == '1) && (x[9:0] == '0);
        return op;
    endfunction

endpackage

// File: rtl/fsub_align_shift.sv
// fsub_align_shift: sticky right shifter for the ALIGN cycle. Every bit
// shifted past the bottom of the working field is ORed into bit 0.
module fsub_align_shift
    import fsub_pkg::*;
(
    input  logic [WORK_W-1:0] sig_in,
    input  logic [EXP_W-1:0]  shamt,
    output logic [WORK_W-1:0] sig_out
);

    logic [2*WORK_W-1:0] wide;

    // Shift into a double-width field so lost bits stay visible for sticky.
    always_comb begin
        wide    = {sig_in, {WORK_W{1'b0}}} >> shamt;
        sig_out = wide[2*WORK_W-1:WORK_W] | {{(WORK_W-1){1'b0}}, |wide[WORK_W-1:0]};
    end

endmodule

// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle binary16 subtractor (result = a - b).
// Optional macro FSUB_SEQ_RNE_EN selects round-to-nearest-even in PACK;
// without it PACK truncates. Cycle count is the same in both builds.
module fsub_seq
    import fsub_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);

    state_t              state_q, state_d;
    operand_t            op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WORK_W-1:0]   large_q, large_d, small_q, small_d;
    logic [WORK_W:0]     work_q, work_d;          // bit 14 = carry, 13 = hidden
    logic [EXPX_W-1:0]   exp_q, exp_d;
    logic                sign_q, sign_d;
    logic                eff_sub_q, eff_sub_d;
    logic [15:0]         result_q, result_d;
    logic                out_valid_q, out_valid_d;

    operand_t            lg, sm;
    logic [EXP_W-1:0]    shamt;
    logic [WORK_W-1:0]   small_aligned;
    logic [SIG_W-1:0]    pk_sig;
    logic [EXPX_W-1:0]   pk_exp;
    logic [15:0]         pack_word;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    // Order operands by magnitude; the smaller one gets aligned.
    always_comb begin
        if ((op_a_q.exp > op_b_q.exp) ||
            ((op_a_q.exp == op_b_q.exp) && (op_a_q.sig >= op_b_q.sig))) begin
            lg = op_a_q;
            sm = op_b_q;
        end else begin
            lg = op_b_q;
            sm = op_a_q;
        end
        shamt = lg.exp - sm.exp;
    end

    fsub_align_shift u_align (
        .sig_in  ({sm.sig, 3'b000}),
        .shamt   (shamt),
        .sig_out (small_aligned)
    );

    // Round (or truncate) the normalised significand and build the output word.
    always_comb begin
`ifdef FSUB_SEQ_RNE_EN
        logic        round_up;
        logic [11:0] rnd_sig;
        round_up = work_q[2] & (work_q[1] | work_q[0] | work_q[3]);
        rnd_sig  = {1'b0, work_q[13:3]} + {11'b0, round_up};
        if (rnd_sig[11]) begin
            pk_sig = rnd_sig[11:1];
            pk_exp = exp_q + 7'd1;
        end else begin
            pk_sig = rnd_sig[10:0];
            pk_exp = exp_q;
        end
`else
        pk_sig = work_q[13:3];
        pk_exp = exp_q;
`endif
        if (op_a_q.is_nan || op_b_q.is_nan) begin
            pack_word = NAN_CANON;
        end else if (op_a_q.is_inf && op_b_q.is_inf) begin
            pack_word = (op_a_q.sign != op_b_q.sign) ? NAN_CANON : {op_a_q.sign, INF_MAG};
        end else if (op_a_q.is_inf) begin
            pack_word = {op_a_q.sign, INF_MAG};
        end else if (op_b_q.is_inf) begin
            pack_word = {op_b_q.sign, INF_MAG};
        end else if (work_q == '0) begin
            pack_word = {op_a_q.sign & op_b_q.sign, 15'h0000};
        end else if (pk_exp >= 7'd31) begin
            pack_word = {sign_q, INF_MAG};
        end else if ((pk_exp < 7'd1) || !pk_sig[10]) begin
            pack_word = {sign_q, 15'h0000};
        end else begin
            pack_word = {sign_q, pk_exp[EXP_W-1:0], pk_sig[FRAC_W-1:0]};
        end
    end

    // Next-state and datapath updates; every register holds unless its stage acts.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        large_d     = large_q;
        small_d     = small_q;
        work_d      = work_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = unpack_op(a, 1'b0);
                    op_b_d  = unpack_op(b, 1'b1);
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                large_d   = {lg.sig, 3'b000};
                small_d   = small_aligned;
                exp_d     = {2'b00, lg.exp};
                sign_d    = lg.sign;
                eff_sub_d = op_a_q.sign ^ op_b_q.sign;
                state_d   = ARITH;
            end
            ARITH: begin
                work_d  = eff_sub_q ? ({1'b0, large_q} - {1'b0, small_q})
                                    : ({1'b0, large_q} + {1'b0, small_q});
                state_d = NORM;
            end
            NORM: begin
                if (work_q[WORK_W]) begin
                    work_d = {1'b0, work_q[WORK_W:2], work_q[1] | work_q[0]};
                    exp_d  = exp_q + 7'd1;
                end else if (!work_q[WORK_W-1] && (work_q != '0) && (exp_q > 7'd1)) begin
                    work_d = {work_q[WORK_W-1:0], 1'b0};
                    exp_d  = exp_q - 7'd1;
                end else begin
                    state_d = PACK;
                end
            end
            PACK: begin
                result_d    = pack_word;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            large_q     <= '0;
            small_q     <= '0;
            work_q      <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            result_q    <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            large_q     <= large_d;
            small_q     <= small_d;
            work_q      <= work_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_fsub_seq.sv
// tb_fsub_seq: directed vectors for fsub_seq with hand-computed results
// and latencies. Inputs are driven and outputs sampled on the falling edge.
module tb_fsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fsub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Present one operand pair and return on the falling edge after the accept.
    task automatic start_op(input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        check_eq("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count rising edges from accept until out_valid, bounded.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] want, input int want_lat);
        int lat;
        start_op(va, vb);
        wait_result(lat);
        $display("op %s: 0x%04h - 0x%04h -> 0x%04h after %0d cycles", tag, va, vb, result, lat);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_eq({tag, "_result"}, {16'b0, result}, {16'b0, want});
        check_eq({tag, "_latency"}, lat, want_lat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_result", {16'b0, result}, 32'h0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;

        run_op("three_minus_one", 16'h4200, 16'h3C00, 16'h4000, 4);
        run_op("one_minus_neg_one", 16'h3C00, 16'hBC00, 16'h4000, 5);
        run_op("cancel", 16'h3C00, 16'h3C00, 16'h0000, 4);
        run_op("inf_minus_inf", 16'h7C00, 16'h7C00, 16'h7E00, 4);
        run_op("inf_minus_neg_inf", 16'h7C00, 16'hFC00, 16'h7C00, 5);
        run_op("nan_input", 16'h3C00, 16'h7E01, 16'h7E00, 4);
        run_op("overflow", 16'h7BFF, 16'hFBFF, 16'h7C00, 5);
        run_op("long_norm", 16'h3C01, 16'h3C00, 16'h1400, 14);
`ifdef FSUB_SEQ_RNE_EN
        run_op("round_tie", 16'h6800, 16'h3800, 16'h6800, 5);
`else
        run_op("round_tie", 16'h6800, 16'h3800, 16'h67FF, 5);
`endif

        // Back-pressure in DONE: output held, new operands ignored.
        start_op(16'h4200, 16'h3C00);
        wait_result(lat);
        $display("op hold: 0x4200 - 0x3C00 -> 0x%04h after %0d cycles, stalling", result, lat);
        for (int i = 0; i < 3; i++) begin
            a        = 16'h7C00;
            b        = 16'h3C00;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("hold_result", {16'b0, result}, 32'h4000);
            check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
            check_eq("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("hold_release_valid", {31'b0, out_valid}, 32'd0);
        check_eq("hold_release_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("hold_release_busy", {31'b0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check_eq("hold_nothing_queued_busy", {31'b0, busy}, 32'd0);
        check_eq("hold_nothing_queued_valid", {31'b0, out_valid}, 32'd0);

        // Reset in the middle of a long normalisation.
        start_op(16'h3C01, 16'h3C00);
        repeat (4) @(negedge clk);
        check_eq("mid_norm_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check_eq("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("post_rst_result", {16'b0, result}, 32'h0);
        repeat (15) @(negedge clk);
        check_eq("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
        $display("op reset: 0x3C01 - 0x3C00 abandoned mid-normalisation");
        run_op("after_reset", 16'h4200, 16'h3C00, 16'h4000, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
